move_repeat_gen: RTL and testbench

Parametrised button-to-movement pulse generator for the Labyrinth ball. It replaces the fixed 30 Hz tick ANDed with held buttons at the top level. A single shared prescaler produces a game tick. Each of NUM_CH channels turns a debounced held button into one-cycle step pulses: an immediate step on press, a hold delay, a slow auto-repeat, then a fast auto-repeat. The block sits between the debounce outputs and the Ball movement inputs.

---
 rtl/move_repeat_pkg.sv | 19 +
 rtl/move_repeat_gen_if.sv | 16 +
 rtl/move_repeat_ch.sv | 116 +++++++++++
 rtl/move_repeat_gen.sv | 63 ++++++
 tb/tb_move_repeat_gen.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/move_repeat_pkg.sv
// Shared types and helpers for the button-to-movement repeat generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package move_repeat_pkg;

  // Per-channel auto-repeat phases.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    SLOW  = 2'd2,
    FAST  = 2'd3
  } state_t;

  // Width needed to count 0..x-1, never less than one bit.
  function automatic int CW(input int x);
    return (x < 2) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/move_repeat_gen_if.sv
// Button levels in, step/fast/tick pulses out for the repeat generator.
// Latency: n/a (wires only).
// Backpressure: none; all signals are level or single-cycle strobes.
interface move_repeat_gen_if #(
  parameter int NUM_CH = 4
);
  logic              en;
  logic [NUM_CH-1:0] btn;
  logic [NUM_CH-1:0] step;
  logic [NUM_CH-1:0] fast;
  logic              tick;

  // master drives the buttons (debounce side), slave is the generator
  modport master (output en, output btn, input step, input fast, input tick);
  modport slave  (input en, input btn, output step, output fast, output tick);
endinterface

// File: rtl/move_repeat_ch.sv
// One button channel: press step, hold delay, slow repeat, then fast repeat.
// Latency: 1 cycle from press or qualifying tick to registered step.
// Backpressure: none; release (go low) aborts to IDLE and beats any step.
module move_repeat_ch
  import move_repeat_pkg::*;
#(
  parameter int DELAY_TICKS = 15,
  parameter int SLOW_DIV    = 4,
  parameter int ACCEL_STEPS = 8,
  parameter int FAST_DIV    = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic go,      // button held and block enabled
  input  logic tick,    // prescaler strobe, same cycle the top registers its tick
  output logic step,
  output logic fast
);

  localparam int TMAX_DS = (DELAY_TICKS > SLOW_DIV) ? DELAY_TICKS : SLOW_DIV;
  localparam int TMAX    = (TMAX_DS > FAST_DIV) ? TMAX_DS : FAST_DIV;
  localparam int TCW     = CW(TMAX);
  localparam int SCW     = CW(ACCEL_STEPS);

  localparam logic [TCW-1:0] DLY_LAST  = TCW'(DELAY_TICKS - 1);
  localparam logic [TCW-1:0] SLOW_LAST = TCW'(SLOW_DIV - 1);
  localparam logic [TCW-1:0] FAST_LAST = TCW'(FAST_DIV - 1);
  localparam logic [SCW-1:0] ACC_LAST  = SCW'(ACCEL_STEPS - 1);

  state_t         state, state_nxt;
  logic [TCW-1:0] tc, tc_nxt;
  logic [SCW-1:0] sc, sc_nxt;
  logic           at_last;
  logic           step_nxt, fast_nxt;

  // Tick counter has reached the period of the current phase.
  always_comb begin
    at_last = 1'b0;
    case (state)
      DELAY:   at_last = (tc == DLY_LAST);
      SLOW:    at_last = (tc == SLOW_LAST);
      FAST:    at_last = (tc == FAST_LAST);
      default: at_last = 1'b0;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tc    <= '0;
      sc    <= '0;
      step  <= 1'b0;
      fast  <= 1'b0;
    end else begin
      state <= state_nxt;
      tc    <= tc_nxt;
      sc    <= sc_nxt;
      step  <= step_nxt;
      fast  <= fast_nxt;
    end
  end

  // Next phase and counter values; release always returns to IDLE.
  always_comb begin
    state_nxt = state;
    tc_nxt    = tc;
    sc_nxt    = sc;
    if (!go) begin
      state_nxt = IDLE;
      tc_nxt    = '0;
      sc_nxt    = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = DELAY;
          tc_nxt    = '0;
          sc_nxt    = '0;
        end
        DELAY: if (tick) begin
          if (at_last) begin
            state_nxt = SLOW;
            tc_nxt    = '0;
            sc_nxt    = '0;
          end else begin
            tc_nxt = tc + TCW'(1);
          end
        end
        SLOW: if (tick) begin
          if (at_last) begin
            tc_nxt = '0;
            if (sc == ACC_LAST) begin
              state_nxt = FAST;
              sc_nxt    = '0;
            end else begin
              sc_nxt = sc + SCW'(1);
            end
          end else begin
            tc_nxt = tc + TCW'(1);
          end
        end
        FAST: if (tick) begin
          tc_nxt = at_last ? '0 : tc + TCW'(1);
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Step on a fresh press or at the end of each phase period; fast mirrors the next state.
  always_comb begin
    step_nxt = go && ((state == IDLE) || (tick && at_last));
    fast_nxt = (state_nxt == FAST);
  end

endmodule

// File: rtl/move_repeat_gen.sv
// Shared game-tick prescaler feeding NUM_CH independent auto-repeat channels.
// Latency: 1 cycle press->step and tick->step; tick and its steps align.
// Backpressure: none; en low forces every channel idle, prescaler keeps running.
module move_repeat_gen
  import move_repeat_pkg::*;
#(
  parameter int CLK_HZ      = 100000000,
  parameter int TICK_HZ     = 60,
  parameter int NUM_CH      = 4,
  parameter int DELAY_TICKS = 15,
  parameter int SLOW_DIV    = 4,
  parameter int ACCEL_STEPS = 8,
  parameter int FAST_DIV    = 1
) (
  input  logic             clk,
  input  logic             reset,
  move_repeat_gen_if.slave bus
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PCW      = CW(TICK_DIV);
  localparam logic [PCW-1:0] PCNT_LAST = PCW'(TICK_DIV - 1);

  logic [PCW-1:0]    pcnt;
  logic              tick_pre;
  logic              tick_q;
  logic [NUM_CH-1:0] step_v;
  logic [NUM_CH-1:0] fast_v;

  assign tick_pre = (pcnt == PCNT_LAST);

  // Free-running prescaler; tick is registered so it lines up with channel steps.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt   <= '0;
      tick_q <= 1'b0;
    end else begin
      pcnt   <= tick_pre ? '0 : pcnt + PCW'(1);
      tick_q <= tick_pre;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    move_repeat_ch #(
      .DELAY_TICKS (DELAY_TICKS),
      .SLOW_DIV    (SLOW_DIV),
      .ACCEL_STEPS (ACCEL_STEPS),
      .FAST_DIV    (FAST_DIV)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .go    (bus.en & bus.btn[i]),
      .tick  (tick_pre),
      .step  (step_v[i]),
      .fast  (fast_v[i])
    );
  end

  assign bus.step = step_v;
  assign bus.fast = fast_v;
  assign bus.tick = tick_q;

endmodule

// File: tb/tb_move_repeat_gen.sv
// Self-checking bench for move_repeat_gen against a tick-count reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_move_repeat_gen;

  localparam int TDIV = 10;
  localparam int NCH  = 4;
  localparam int D    = 3;
  localparam int S    = 2;
  localparam int A    = 3;
  localparam int F    = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  move_repeat_gen_if #(.NUM_CH(NCH)) bus();

  move_repeat_gen #(
    .CLK_HZ(100), .TICK_HZ(10), .NUM_CH(NCH), .DELAY_TICKS(D),
    .SLOW_DIV(S), .ACCEL_STEPS(A), .FAST_DIV(F)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: each held channel counts ticks since its press (k).
  // Steps fall at k = D, then D+S*j for j=1..A, then every F ticks; fast from k >= D+S*A.
  int               m_n;
  bit               m_act [NCH];
  int               m_k   [NCH];
  logic [NCH-1:0]   exp_step, exp_fast;
  logic             exp_tick;

  function automatic bit due(input int k);
    if (k == D) return 1'b1;
    if (k > D && k <= D + S*A) return ((k - D) % S) == 0;
    if (k > D + S*A) return ((k - D - S*A) % F) == 0;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_n = 0; exp_step = '0; exp_fast = '0; exp_tick = 1'b0;
      for (int c = 0; c < NCH; c++) begin m_act[c] = 1'b0; m_k[c] = 0; end
    end else begin
      m_n++;
      exp_tick = ((m_n % TDIV) == 0);
      for (int c = 0; c < NCH; c++) begin
        if (!(bus.en && bus.btn[c])) begin
          m_act[c] = 1'b0; exp_step[c] = 1'b0; exp_fast[c] = 1'b0;
        end else if (!m_act[c]) begin
          m_act[c] = 1'b1; m_k[c] = 0; exp_step[c] = 1'b1; exp_fast[c] = 1'b0;
        end else begin
          if (exp_tick) m_k[c]++;
          exp_step[c] = exp_tick && due(m_k[c]);
          exp_fast[c] = (m_k[c] >= D + S*A);
        end
      end
    end
  end

  // Idle until the model says a tick just happened (bounded, model-driven).
  task automatic sync_tick();
    for (int i = 0; i < 2*TDIV; i++) begin
      @(negedge clk);
      if (exp_tick) break;
    end
  endtask

  task automatic test_reset();
    int first, second;
    reset = 1'b1; bus.en = 1'b1; bus.btn = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_total++;
      if ({bus.step, bus.fast, bus.tick} !== '0)
        $display("FAIL reset_hold cyc=%0d step/fast/tick got %b/%b/%b exp 0", i, bus.step, bus.fast, bus.tick);
      else n_pass++;
    end
    reset = 1'b0; first = -1; second = -1;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      n_total++;
      if ({bus.step, bus.fast, bus.tick} !== {exp_step, exp_fast, exp_tick})
        $display("FAIL reset_run cyc=%0d got %b/%b/%b exp %b/%b/%b", i, bus.step, bus.fast, bus.tick, exp_step, exp_fast, exp_tick);
      else n_pass++;
      if (bus.tick === 1'b1) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    n_total++;
    if (first !== 10) $display("FAIL first_tick got cycle %0d exp 10", first); else n_pass++;
    n_total++;
    if (second !== 20) $display("FAIL second_tick got cycle %0d exp 20", second); else n_pass++;
  endtask

  task automatic test_single_hold();
    int q[$];
    int fast_rise;
    sync_tick();
    bus.btn[0] = 1'b1; fast_rise = -1;
    for (int i = 1; i <= 139; i++) begin
      @(negedge clk);
      n_total++;
      if ({bus.step, bus.fast, bus.tick} !== {exp_step, exp_fast, exp_tick})
        $display("FAIL hold cyc=%0d got %b/%b/%b exp %b/%b/%b", i, bus.step, bus.fast, bus.tick, exp_step, exp_fast, exp_tick);
      else n_pass++;
      if (i <= 130 && bus.step[0] === 1'b1) q.push_back(i);
      if (bus.fast[0] === 1'b1 && fast_rise < 0) fast_rise = i;
    end
    n_total++;
    if (q.size() != 9) $display("FAIL hold_count got %0d steps exp 9", q.size()); else n_pass++;
    n_total++;
    if ((q.size() > 0 ? q[0] : -1) != 1) $display("FAIL press_step got cycle %0d exp 1", q.size() > 0 ? q[0] : -1); else n_pass++;
    n_total++;
    if ((q.size() > 1 ? q[1] - q[0] : -1) != 29) $display("FAIL delay_gap got %0d exp 29", q.size() > 1 ? q[1] - q[0] : -1); else n_pass++;
    n_total++;
    if ((q.size() > 4 ? q[4] : -1) != 90) $display("FAIL third_slow got cycle %0d exp 90", q.size() > 4 ? q[4] : -1); else n_pass++;
    n_total++;
    if (fast_rise != 90) $display("FAIL fast_rise got cycle %0d exp 90", fast_rise); else n_pass++;
    // release on the cycle a fast step would fire
    bus.btn[0] = 1'b0;
    @(negedge clk);
    n_total++;
    if ({bus.step[0], bus.fast[0], bus.tick} !== 3'b001)
      $display("FAIL fast_release step/fast/tick got %b%b%b exp 001", bus.step[0], bus.fast[0], bus.tick);
    else n_pass++;
  endtask

  task automatic test_delay_release();
    int cnt;
    sync_tick();
    bus.btn[0] = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      @(negedge clk);
      n_total++;
      if ({bus.step, bus.fast, bus.tick} !== {exp_step, exp_fast, exp_tick})
        $display("FAIL dly cyc=%0d got %b/%b/%b exp %b/%b/%b", i, bus.step, bus.fast, bus.tick, exp_step, exp_fast, exp_tick);
      else n_pass++;
    end
    bus.btn[0] = 1'b0; cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt += int'(bus.step[0] === 1'b1);
    end
    n_total++;
    if (cnt != 0) $display("FAIL dly_release got %0d steps exp 0", cnt); else n_pass++;
    bus.btn[0] = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.step[0] !== 1'b1) $display("FAIL repress step got %b exp 1", bus.step[0]); else n_pass++;
    bus.btn[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_en_gate();
    int cnt;
    bus.en = 1'b0; bus.btn[1] = 1'b1; cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cnt += int'(bus.step !== '0);
    end
    n_total++;
    if (cnt != 0) $display("FAIL en_low got %0d step cycles exp 0", cnt); else n_pass++;
    bus.en = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.step !== 4'b0010) $display("FAIL en_rise step got %b exp 0010", bus.step); else n_pass++;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      n_total++;
      if ({bus.step, bus.fast, bus.tick} !== {exp_step, exp_fast, exp_tick})
        $display("FAIL en_run cyc=%0d got %b/%b/%b exp %b/%b/%b", i, bus.step, bus.fast, bus.tick, exp_step, exp_fast, exp_tick);
      else n_pass++;
    end
    bus.btn[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_two_channels();
    int q0[$], q2[$];
    sync_tick();
    bus.btn[0] = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      if (i == 2) bus.btn[2] = 1'b1;
      @(negedge clk);
      n_total++;
      if ({bus.step, bus.fast, bus.tick} !== {exp_step, exp_fast, exp_tick})
        $display("FAIL two cyc=%0d got %b/%b/%b exp %b/%b/%b", i, bus.step, bus.fast, bus.tick, exp_step, exp_fast, exp_tick);
      else n_pass++;
      if (bus.step[0] === 1'b1) q0.push_back(i);
      if (bus.step[2] === 1'b1) q2.push_back(i);
    end
    n_total++;
    if ((q0.size() > 0 && q2.size() > 0 ? q2[0] - q0[0] : -99) != 1)
      $display("FAIL press_offset got %0d exp 1", q0.size() > 0 && q2.size() > 0 ? q2[0] - q0[0] : -99);
    else n_pass++;
    n_total++;
    if ((q0.size() > 1 ? q0[1] : -1) != 30 || (q2.size() > 1 ? q2[1] : -1) != 30)
      $display("FAIL repeat_align got %0d/%0d exp 30/30", q0.size() > 1 ? q0[1] : -1, q2.size() > 1 ? q2[1] : -1);
    else n_pass++;
    // reset in mid-run with buttons still held
    reset = 1'b1;
    @(negedge clk);
    n_total++;
    if ({bus.step, bus.fast, bus.tick} !== '0)
      $display("FAIL mid_reset got %b/%b/%b exp 0", bus.step, bus.fast, bus.tick);
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.step !== 4'b0101) $display("FAIL post_reset_press step got %b exp 0101", bus.step); else n_pass++;
    bus.btn = '0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [NCH-1:0] prev;
    prev = '0;
    for (int i = 0; i < 900; i++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(29, 0) == 0) bus.btn[c] = ~bus.btn[c];
      if (bus.en) begin if ($urandom_range(149, 0) == 0) bus.en = 1'b0; end
      else if ($urandom_range(9, 0) == 0) bus.en = 1'b1;
      reset = ($urandom_range(399, 0) == 0);
      @(negedge clk);
      n_total++;
      if ({bus.step, bus.fast, bus.tick} !== {exp_step, exp_fast, exp_tick})
        $display("FAIL rand cyc=%0d got %b/%b/%b exp %b/%b/%b", i, bus.step, bus.fast, bus.tick, exp_step, exp_fast, exp_tick);
      else n_pass++;
      n_total++;
      if ((prev & bus.step) !== '0) $display("FAIL step_gap cyc=%0d prev %b now %b exp no overlap", i, prev, bus.step);
      else n_pass++;
      prev = bus.step;
    end
    reset = 1'b0; bus.en = 1'b1; bus.btn = '0;
  endtask

  initial begin
    reset = 1'b1; bus.en = 1'b1; bus.btn = '0;
    test_reset();
    test_single_hold();
    test_delay_release();
    test_en_gate();
    test_two_channels();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
